// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word types, forward S-box table and Rcon lookup.
// Used by both the key schedule and the cipher datapath.
package aes_pkg;

   typedef logic [7:0]  byte_t;
   typedef logic [31:0] word_t;

   localparam byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic byte_t sbox(input byte_t b);
      return SBOX[b];
   endfunction

   // Indices outside 1..10 are legal and simply drop the Rcon term.
   function automatic byte_t rcon(input logic [3:0] idx);
      byte_t r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte wide.
// Shared by the key schedule (SubWord) and the cipher rounds (SubBytes).
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);

   always_comb begin
      sub_val = sbox(byte_val);
   end

endmodule

// File: rtl/key_expansion_stage.sv
// One AES-128 key-schedule round as a registered stage: out_key is the next
// round key one clock after in_key/round_idx are presented.
module key_expansion_stage
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rstn,
   input  logic [127:0] in_key,
   input  logic [3:0]   round_idx,
   output logic [127:0] out_key
);

   word_t w0, w1, w2, w3;
   word_t rot, sub, t;
   word_t n0, n1, n2, n3;

   always_comb begin
      w0  = in_key[127:96];
      w1  = in_key[95:64];
      w2  = in_key[63:32];
      w3  = in_key[31:0];
      rot = {w3[23:0], w3[31:24]};
   end

   for (genvar i = 0; i < 4; i++) begin : g_subword
      aes_sbox u_sbox (
         .byte_val (rot[8*i +: 8]),
         .sub_val  (sub[8*i +: 8])
      );
   end

   always_comb begin
      t  = sub ^ {rcon(round_idx), 24'h0};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
   end

   // rstn is active-high despite its name.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) out_key <= '0;
      else      out_key <= {n0, n1, n2, n3};
   end

endmodule

// File: tb/tb_key_expansion_stage.sv
// Self-checking bench for key_expansion_stage; the reference derives the S-box
// and Rcon from GF(2^8) arithmetic rather than from tables.
module tb_key_expansion_stage;

   logic         clk;
   logic         rstn;
   logic [127:0] in_key;
   logic [3:0]   round_idx;
   logic [127:0] out_key;

   int checks = 0;
   int errors = 0;
   logic         chk_en = 1'b0;
   logic [127:0] exp_key;

   key_expansion_stage dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_key    (in_key),
      .round_idx (round_idx),
      .out_key   (out_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] x);
      logic [7:0] inv, r, s;
      inv = 8'h00;
      for (int v = 1; v < 256; v++)
         if (x != 8'h00 && gmul(x, 8'(v)) == 8'h01) inv = 8'(v);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon_model(input int idx);
      logic [7:0] r;
      if (idx < 1 || idx > 10) return 8'h00;
      r = 8'h01;
      for (int k = 1; k < idx; k++) r = gmul(r, 8'h02);
      return r;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] key, input logic [3:0] idx);
      logic [31:0] w [8];
      logic [31:0] temp;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      temp = {w[3][23:0], w[3][31:24]};
      for (int b = 0; b < 4; b++) temp[8*b +: 8] = sbox_model(temp[8*b +: 8]);
      temp = temp ^ {rcon_model(int'(idx)), 24'h0};
      for (int i = 4; i < 8; i++) begin
         w[i] = w[i-4] ^ temp;
         temp = w[i];
      end
      return {w[4], w[5], w[6], w[7]};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference register: one-cycle latency, asynchronous clear.
   always @(posedge clk or posedge rstn) begin
      if (rstn) exp_key = '0;
      else      exp_key = model(in_key, round_idx);
   end

   always @(negedge clk) begin
      if (chk_en) check("cycle_compare", out_key, exp_key);
   end

   task automatic run_chain(input logic [127:0] key, input logic [127:0] r1,
                            input logic [127:0] r2, input logic [127:0] r10, input string tag);
      rstn = 1'b0;
      in_key = key;
      round_idx = 4'd1;
      @(negedge clk);
      check({tag, "_round1"}, out_key, r1);
      for (int r = 2; r <= 10; r++) begin
         in_key = out_key;
         round_idx = 4'(r);
         @(negedge clk);
         if (r == 2 && r2 != '0) check({tag, "_round2"}, out_key, r2);
         if (r == 10) check({tag, "_round10"}, out_key, r10);
      end
   endtask

   initial begin
      logic [3:0]  oor [6];
      logic [7:0]  bv;
      oor[0] = 4'd0;  oor[1] = 4'd11; oor[2] = 4'd12;
      oor[3] = 4'd13; oor[4] = 4'd14; oor[5] = 4'd15;

      rstn = 1'b0;
      in_key = {$urandom, $urandom, $urandom, $urandom};
      round_idx = 4'($urandom_range(0, 15));
      #2 rstn = 1'b1;
      #1 check("reset_async", out_key, 128'h0);
      @(negedge clk);
      chk_en = 1'b1;
      in_key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("reset_hold", out_key, 128'h0);

      run_chain(128'h000102030405060708090a0b0c0d0e0f,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'hb692cf0b643dbdf1be9bc5006830b3fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, "fips_c1");
      run_chain(128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'h0,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_a1");

      for (int n = 0; n < 24; n++) begin
         in_key = {$urandom, $urandom, $urandom, $urandom};
         round_idx = oor[n % 6];
         @(negedge clk);
      end

      for (int b = 0; b < 256; b++) begin
         bv = 8'(b);
         in_key = {$urandom, $urandom, $urandom, bv, bv, bv, bv};
         round_idx = 4'($urandom_range(0, 15));
         @(negedge clk);
      end

      for (int n = 0; n < 400; n++) begin
         in_key = {$urandom, $urandom, $urandom, $urandom};
         round_idx = 4'($urandom_range(0, 15));
         if (n == 200) begin
            #2 rstn = 1'b1;
            #1 check("reset_mid", out_key, 128'h0);
            @(negedge clk);
            check("reset_mid_hold", out_key, 128'h0);
            rstn = 1'b0;
            in_key = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
